// File: rtl/ifc_host_master.sv
// IFC single-beat bus initiator for the host end of the src3cpld link.
// Request/response front end driving multiplexed AD read and write cycles.
module ifc_host_master #(
    parameter int unsigned ADDR_CYC   = 3,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned WSETUP_CYC = 3,
    parameter int unsigned WE_CYC     = 4,
    parameter int unsigned RD_CYC     = 2,
    parameter int unsigned RECOV_CYC  = 2
) (
    input  logic        clock_50MHz,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] ifc_ad_o,
    output logic        ifc_ad_oe,
    input  logic [15:0] ifc_ad_i,
    output logic [7:0]  ifc_addr,
    output logic        ifc_avd,
    output logic        ifc_cs,
    output logic        ifc_oe_b,
    output logic        ifc_we_b
);

    localparam logic [7:0] ADDR_LD   = 8'(ADDR_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] WSETUP_LD = 8'(WSETUP_CYC - 1);
    localparam logic [7:0] WE_LD     = 8'(WE_CYC - 1);
    localparam logic [7:0] RD_LD     = 8'(RD_CYC - 1);
    localparam logic [7:0] RECOV_LD  = 8'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD,
        WSETUP,
        WSTROBE,
        RSTROBE,
        RECOV
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        wr_q;
    logic [15:0] wdata_q;

    // IFC lane order: AD[0] carries the most significant bit.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Bus cycle sequencer; every bus pin and response output is registered here.
    always_ff @(posedge clock_50MHz) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ifc_ad_o  <= '0;
            ifc_ad_oe <= 1'b0;
            ifc_addr  <= '0;
            ifc_avd   <= 1'b0;
            ifc_cs    <= 1'b1;
            ifc_oe_b  <= 1'b1;
            ifc_we_b  <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_wr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        ifc_ad_oe <= 1'b1;
                        ifc_ad_o  <= {8'h00, rev8(req_addr)};
                        ifc_addr  <= rev8(req_addr);
                        ifc_avd   <= 1'b1;
                        cnt       <= ADDR_LD;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        ifc_avd <= 1'b0;
                        cnt     <= HOLD_LD;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (wr_q) begin
                        ifc_ad_o <= rev16(wdata_q);
                        ifc_cs   <= 1'b0;
                        cnt      <= WSETUP_LD;
                        state    <= WSETUP;
                    end else begin
                        ifc_ad_oe <= 1'b0;
                        ifc_cs    <= 1'b0;
                        ifc_oe_b  <= 1'b0;
                        cnt       <= RD_LD;
                        state     <= RSTROBE;
                    end
                end
                WSETUP: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        ifc_we_b <= 1'b0;
                        cnt      <= WE_LD;
                        state    <= WSTROBE;
                    end
                end
                WSTROBE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        ifc_we_b  <= 1'b1;
                        ifc_cs    <= 1'b1;
                        rsp_valid <= 1'b1;
                        cnt       <= RECOV_LD;
                        state     <= RECOV;
                    end
                end
                RSTROBE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        rsp_rdata <= rev16(ifc_ad_i);
                        ifc_cs    <= 1'b1;
                        ifc_oe_b  <= 1'b1;
                        rsp_valid <= 1'b1;
                        cnt       <= RECOV_LD;
                        state     <= RECOV;
                    end
                end
                RECOV: begin
                    ifc_ad_oe <= 1'b0;
                    ifc_ad_o  <= '0;
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        ifc_addr  <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifc_host_master.sv
// Self-checking bench for ifc_host_master.
// Timing and data expectations come from phase lengths and lane reversal.
module tb_ifc_host_master;

    localparam int A   = 3;
    localparam int H   = 2;
    localparam int WS  = 3;
    localparam int WE  = 4;
    localparam int R   = 2;
    localparam int RC  = 2;
    localparam int PER = 10;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] ifc_ad_o;
    logic        ifc_ad_oe;
    logic [15:0] ifc_ad_i;
    logic [7:0]  ifc_addr;
    logic        ifc_avd;
    logic        ifc_cs;
    logic        ifc_oe_b;
    logic        ifc_we_b;

    logic [15:0] slave_word;

    int total;
    int bad;
    int viol;

    ifc_host_master #(
        .ADDR_CYC(A),
        .HOLD_CYC(H),
        .WSETUP_CYC(WS),
        .WE_CYC(WE),
        .RD_CYC(R),
        .RECOV_CYC(RC)
    ) dut (
        .clock_50MHz(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ifc_ad_o(ifc_ad_o),
        .ifc_ad_oe(ifc_ad_oe),
        .ifc_ad_i(ifc_ad_i),
        .ifc_addr(ifc_addr),
        .ifc_avd(ifc_avd),
        .ifc_cs(ifc_cs),
        .ifc_oe_b(ifc_oe_b),
        .ifc_we_b(ifc_we_b)
    );

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    // Slave drives its word only while the output enable strobe is low.
    assign ifc_ad_i = ifc_oe_b ? 16'h0000 : slave_word;

    // Bus protocol monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!ifc_oe_b && !ifc_we_b) viol++;
            if (ifc_avd && !ifc_cs) viol++;
            if (!ifc_oe_b && ifc_ad_oe) viol++;
        end
    end

    function automatic logic [7:0] rv8(input logic [7:0] v);
        logic [7:0] r;
        r = {<<{v}};
        return r;
    endfunction

    function automatic logic [15:0] rv16(input logic [15:0] v);
        logic [15:0] r;
        r = {<<{v}};
        return r;
    endfunction

    // Issue one request (called at a negedge) and record what the bus did.
    task automatic drive_txn(
        input  logic        wr,
        input  logic [7:0]  a,
        input  logic [15:0] d,
        input  logic [15:0] sw,
        input  logic        keep,
        input  logic        scramble,
        output int          lat,
        output int          kend,
        output int          avd_n,
        output int          cs_n,
        output int          we_n,
        output int          oe_n,
        output int          dat_n,
        output int          we_out,
        output logic [15:0] ad_first,
        output logic        addr_ok,
        output time         t_acc
    );
        logic [7:0]  ar;
        logic [15:0] dr;
        int          lo;
        int          hi;
        int          g;
        ar = rv8(a);
        dr = rv16(d);
        lo = A + H + 1;
        hi = A + H + WS + WE + 1;
        lat = 0; kend = 0; avd_n = 0; cs_n = 0; we_n = 0;
        oe_n = 0; dat_n = 0; we_out = 0; ad_first = 'x;
        addr_ok = 1'b1;
        slave_word = sw;
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = a;
        req_wdata = d;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        if (scramble) begin
            req_addr = ~a;
            req_wdata = ~d;
            req_wr = ~wr;
        end
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid && lat == 0) lat = k;
            if (ifc_avd) avd_n++;
            if (!ifc_cs) cs_n++;
            if (!ifc_we_b) we_n++;
            if (!ifc_we_b && ifc_cs) we_out++;
            if (!ifc_oe_b) oe_n++;
            if (k == 1) ad_first = ifc_ad_o;
            if (k >= lo && k <= hi && ifc_ad_oe && ifc_ad_o == dr) dat_n++;
            if (req_ready) begin
                kend = k;
                if (ifc_addr !== 8'h00) addr_ok = 1'b0;
                break;
            end
            if (ifc_addr !== ar) addr_ok = 1'b0;
            if (k < 40) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        total++;
        if (rsp_rdata !== 16'h0000 || ifc_ad_o !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data rdata=%h ad_o=%h want 0 0", rsp_rdata, ifc_ad_o);
        end
        total++;
        if (ifc_ad_oe !== 1'b0 || ifc_addr !== 8'h00 || ifc_avd !== 1'b0) begin
            bad++;
            $display("FAIL reset_bus oe=%b addr=%h avd=%b want 0 00 0", ifc_ad_oe, ifc_addr, ifc_avd);
        end
        total++;
        if ({ifc_cs, ifc_oe_b, ifc_we_b} !== 3'b111) begin
            bad++;
            $display("FAIL reset_strb got=%b want 111", {ifc_cs, ifc_oe_b, ifc_we_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        int lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out;
        logic [15:0] adf;
        logic aok;
        time t;
        drive_txn(1'b0, 8'h10, 16'h0000, 16'h8000, 1'b0, 1'b0,
                  lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out, adf, aok, t);
        total++;
        if (adf !== 16'h0008) begin
            bad++;
            $display("FAIL rd_addr_phase ad_o=%h want 0008", adf);
        end
        total++;
        if (avd_n != A) begin
            bad++;
            $display("FAIL rd_avd_len got=%0d want %0d", avd_n, A);
        end
        total++;
        if (lat != A + H + R + 1) begin
            bad++;
            $display("FAIL rd_latency got=%0d want %0d", lat, A + H + R + 1);
        end
        total++;
        if (rsp_rdata !== 16'h0001) begin
            bad++;
            $display("FAIL rd_data got=%h want 0001", rsp_rdata);
        end
        total++;
        if (oe_n != R || cs_n != R || we_n != 0) begin
            bad++;
            $display("FAIL rd_strobes oe=%0d cs=%0d we=%0d want %0d %0d 0", oe_n, cs_n, we_n, R, R);
        end
        total++;
        if (kend != A + H + R + RC + 1 || !aok) begin
            bad++;
            $display("FAIL rd_busy kend=%0d addr_ok=%b want %0d 1", kend, aok, A + H + R + RC + 1);
        end
    endtask

    task automatic test_write();
        int lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out;
        logic [15:0] adf;
        logic aok;
        time t;
        drive_txn(1'b1, 8'h40, 16'h0103, 16'h0000, 1'b0, 1'b0,
                  lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out, adf, aok, t);
        total++;
        if (adf !== 16'h0002) begin
            bad++;
            $display("FAIL wr_addr_phase ad_o=%h want 0002", adf);
        end
        total++;
        if (dat_n != WS + WE + 1) begin
            bad++;
            $display("FAIL wr_data_window got=%0d want %0d cycles of C080", dat_n, WS + WE + 1);
        end
        total++;
        if (we_n != WE || we_out != 0 || cs_n != WS + WE || oe_n != 0) begin
            bad++;
            $display("FAIL wr_strobes we=%0d out=%0d cs=%0d oe=%0d want %0d 0 %0d 0",
                     we_n, we_out, cs_n, oe_n, WE, WS + WE);
        end
        total++;
        if (lat != A + H + WS + WE + 1) begin
            bad++;
            $display("FAIL wr_latency got=%0d want %0d", lat, A + H + WS + WE + 1);
        end
        total++;
        if (kend != A + H + WS + WE + RC + 1 || !aok || rsp_rdata !== 16'h0001) begin
            bad++;
            $display("FAIL wr_busy kend=%0d addr_ok=%b rdata=%h want %0d 1 0001",
                     kend, aok, rsp_rdata, A + H + WS + WE + RC + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [5];
        int lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out;
        logic [15:0] adf;
        logic aok;
        time t;
        time tprev;
        logic [15:0] exp;
        words[0] = 16'h8000;
        words[1] = 16'h4000;
        words[2] = 16'hC000;
        words[3] = 16'h2000;
        words[4] = 16'hA000;
        tprev = 0;
        for (int i = 0; i < 5; i++) begin
            drive_txn(1'b0, 8'h54, 16'h0000, words[i], (i < 4), 1'b0,
                      lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out, adf, aok, t);
            exp = 16'(i + 1);
            total++;
            if (rsp_rdata !== exp || !aok || adf !== 16'h002A) begin
                bad++;
                $display("FAIL b2b_data[%0d] rdata=%h addr_ok=%b ad=%h want %h 1 002a",
                         i, rsp_rdata, aok, adf, exp);
            end
            if (i > 0) begin
                total++;
                if ((t - tprev) / PER != A + H + R + RC + 1) begin
                    bad++;
                    $display("FAIL b2b_spacing[%0d] got=%0d want %0d",
                             i, (t - tprev) / PER, A + H + R + RC + 1);
                end
            end
            tprev = t;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        int g;
        int seen;
        int lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out;
        logic [15:0] adf;
        logic aok;
        time t;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_addr = 8'h33;
        req_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (ifc_we_b && g < 40) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (ifc_we_b !== 1'b0) begin
            bad++;
            $display("FAIL abort_reach_we we_b=%b want 0 within 40 clocks", ifc_we_b);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({ifc_cs, ifc_we_b, ifc_ad_oe, rsp_valid} !== 4'b1100) begin
            bad++;
            $display("FAIL abort_strobes cs/we/oe/valid=%b want 1100",
                     {ifc_cs, ifc_we_b, ifc_ad_oe, rsp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_no_rsp got=%0d pulses want 0", seen);
        end
        drive_txn(1'b0, 8'h01, 16'h0000, 16'h1234, 1'b0, 1'b0,
                  lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out, adf, aok, t);
        total++;
        if (rsp_rdata !== rv16(16'h1234) || lat != A + H + R + 1 || adf !== 16'h0080) begin
            bad++;
            $display("FAIL abort_then_read rdata=%h lat=%0d ad=%h want %h %0d 0080",
                     rsp_rdata, lat, adf, rv16(16'h1234), A + H + R + 1);
        end
    endtask

    task automatic test_latch();
        int lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out;
        logic [15:0] adf;
        logic aok;
        time t;
        drive_txn(1'b1, 8'hC5, 16'h5A3C, 16'h0000, 1'b0, 1'b1,
                  lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out, adf, aok, t);
        total++;
        if (adf !== {8'h00, rv8(8'hC5)} || !aok) begin
            bad++;
            $display("FAIL latch_addr ad=%h addr_ok=%b want %h 1", adf, aok, {8'h00, rv8(8'hC5)});
        end
        total++;
        if (dat_n != WS + WE + 1 || we_n != WE || lat != A + H + WS + WE + 1) begin
            bad++;
            $display("FAIL latch_data dat=%0d we=%0d lat=%0d want %0d %0d %0d",
                     dat_n, we_n, lat, WS + WE + 1, WE, A + H + WS + WE + 1);
        end
    endtask

    task automatic test_random();
        int lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out;
        logic [15:0] adf;
        logic aok;
        time t;
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] sw;
        logic [15:0] last_rd;
        int exp_lat;
        int exp_end;
        last_rd = rsp_rdata;
        viol = 0;
        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            d = 16'($urandom);
            sw = 16'($urandom);
            drive_txn(wr, a, d, sw, 1'b0, 1'b0,
                      lat, kend, avd_n, cs_n, we_n, oe_n, dat_n, we_out, adf, aok, t);
            if (!wr) last_rd = rv16(sw);
            exp_lat = wr ? (A + H + WS + WE + 1) : (A + H + R + 1);
            exp_end = exp_lat + RC;
            total++;
            if (rsp_rdata !== last_rd || lat != exp_lat || kend != exp_end) begin
                bad++;
                $display("FAIL rnd[%0d] wr=%b rdata=%h lat=%0d end=%0d want %h %0d %0d",
                         n, wr, rsp_rdata, lat, kend, last_rd, exp_lat, exp_end);
            end
            total++;
            if (adf !== {8'h00, rv8(a)} || !aok || avd_n != A ||
                dat_n != (wr ? WS + WE + 1 : 0) || we_n != (wr ? WE : 0)) begin
                bad++;
                $display("FAIL rnd_bus[%0d] wr=%b ad=%h aok=%b avd=%0d dat=%0d we=%0d",
                         n, wr, adf, aok, avd_n, dat_n, we_n);
            end
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL protocol violations=%0d want 0", viol);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        viol = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        slave_word = '0;
        test_reset();
        @(negedge clk);
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
        test_latch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifc_host_master.md
Name: ifc_host_master

Overview:
- IFC bus initiator that runs the host end of the 16-bit multiplexed address/data IFC link into src3cpld.
- Turns a simple request/response interface into IFC single-beat read and write cycles: AVD address phase, CS/OE read strobe, CS/WE write strobe.
- Applies the IFC bit-reversed lane order (IFC AD[0] is the MSB) on address and data.
- Used in the FPGA/host-emulation build and as a synthesizable stimulus master for CPLD register and block-transfer bring-up.

Parameters:
- ADDR_CYC, 3: clocks ifc_avd is held high with the address on the bus (min 1).
- HOLD_CYC, 2: clocks the address is held after ifc_avd falls (min 1).
- WSETUP_CYC, 3: clocks write data is driven with ifc_cs low before ifc_we_b falls (min 1).
- WE_CYC, 4: clocks ifc_we_b is held low (min 1).
- RD_CYC, 2: clocks ifc_cs/ifc_oe_b are held low before read data is sampled (min 1).
- RECOV_CYC, 2: bus turnaround clocks after any cycle before a new request is accepted (min 1).

Ports:
- clock_50MHz  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  8  register address, natural bit order
- req_wdata  in  16  write data, natural bit order
- rsp_valid  out  1  one-clock pulse, transaction complete
- rsp_rdata  out  16  read data, natural order; holds until next read completes
- ifc_ad_o  out  16  AD bus drive value
- ifc_ad_oe  out  1  AD bus output enable (top level builds the tristate)
- ifc_ad_i  in  16  AD bus sampled value
- ifc_addr  out  8  latched address bus (bit-reversed form)
- ifc_avd  out  1  address valid, active high
- ifc_cs  out  1  chip select, active low
- ifc_oe_b  out  1  output enable, active low
- ifc_we_b  out  1  write enable, active low

Behaviour:
- Reset (rst_n=0 at clock edge):
  - state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - ifc_ad_o=0, ifc_ad_oe=0, ifc_addr=0, ifc_avd=0.
  - ifc_cs=1, ifc_oe_b=1, ifc_we_b=1.
  - Reset mid-transaction aborts at once: all strobes deasserted next edge, no rsp_valid.
- All outputs are registered. rev8/rev16 = bit reversal, so output bit i = input bit (N-1-i).
- Acceptance:
  - req_ready=1 only in IDLE; accept on req_valid&req_ready.
  - Latch wr, addr and wdata at acceptance; later changes to req_* are ignored.
- Counter: one cycle counter, reloaded on every state entry with (phase length − 1).
- State sequence:
  - IDLE→ADDR on accept.
  - ADDR (ADDR_CYC clocks):
    - ifc_ad_oe=1; ifc_ad_o={8'h00, rev8(addr)}; ifc_avd=1.
    - ifc_addr=rev8(addr), registered at ADDR entry and held until IDLE is re-entered.
    - Then go to HOLD.
  - HOLD (HOLD_CYC): ifc_avd=0, address still driven. Then WSETUP if wr, else RSTROBE.
  - WSETUP (WSETUP_CYC): ifc_ad_o=rev16(wdata), ifc_cs=0. Then WSTROBE.
  - WSTROBE (WE_CYC): additionally ifc_we_b=0. Then RECOV; ifc_we_b and ifc_cs rise together on RECOV entry, and data stays driven for the first RECOV clock.
  - RSTROBE (RD_CYC): ifc_ad_oe=0 from the first RSTROBE clock (no contention), ifc_cs=0, ifc_oe_b=0. On the last RSTROBE clock, rsp_rdata<=rev16(ifc_ad_i). Then RECOV.
  - RECOV (RECOV_CYC):
    - All strobes high, ifc_ad_oe=0 (write: from the 2nd clock), ifc_addr cleared to 0 on exit.
    - rsp_valid pulses on the first RECOV clock.
    - Then IDLE.
- Latency, accept edge to rsp_valid:
  - read = ADDR_CYC+HOLD_CYC+RD_CYC+1 (defaults: 8).
  - write = ADDR_CYC+HOLD_CYC+WSETUP_CYC+WE_CYC+1 (defaults: 13).
  - Back-to-back: next accept is possible RECOV_CYC clocks after rsp_valid.
- Invariants:
  - ifc_oe_b and ifc_we_b are never both 0.
  - ifc_avd=1 only while ifc_cs=1.
  - ifc_ad_oe=0 whenever ifc_oe_b=0.
- req_valid while busy is held off by req_ready=0 and is not lost.
- X/Z on ifc_ad_i is captured unchanged; there is no timeout (IFC GPCM has no ready).

Test Plan:
- Read addr 0x10, bus model returns ifc_ad=16'h8000 during OE low → ADDR shows ifc_ad_o[7:0]=0x08, ifc_avd high 3 clocks; rsp_valid 8 clocks after accept, rsp_rdata=16'h0001.
- Write addr 0x40, data 16'h0103 → ifc_ad_o[7:0]=0x02 in ADDR, ifc_ad_o=16'hC080 from WSETUP through the first RECOV clock, ifc_we_b low exactly 4 clocks inside ifc_cs low, rsp_valid at clock 13.
- Five back-to-back reads of addr 0x54, req_valid held high, slave returns 16'h8000,4000,C000,2000,A000 → ifc_addr=0x2A in every cycle; rsp_rdata=1,2,3,4,5; accepts spaced 10 clocks apart; req_ready low in between.
- rst_n low during WSTROBE of a write → next edge: ifc_cs=1, ifc_we_b=1, ifc_ad_oe=0, no rsp_valid; a following read completes normally.
- req_addr/req_wdata changed one clock after accept → bus still carries the originally accepted values.
- Protocol checker over random read/write mix (200 transactions): fires on any invariant violation or bus contention (ifc_ad_oe=1 while ifc_oe_b=0).
